// File: rtl/gat_argmax_pkg.sv
// gat_argmax_pkg: FSM state codes, record type and width helpers
// shared by the GAT final-feature argmax block and its bench.
package gat_argmax_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  typedef struct packed {
    logic [15:0] node;
    logic [7:0]  cls;
  } pred_rec_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int class_w(input int n_cls);
    return idx_w(n_cls);
  endfunction

  function automatic int node_w(input int n_nodes);
    return idx_w(n_nodes);
  endfunction

endpackage

// File: rtl/gat_feat_argmax_if.sv
// gat_feat_argmax_if: valid/ready record stream (node, class).
// master drives valid/node/class, slave drives ready.
interface gat_feat_argmax_if #(
  parameter int NODE_W  = 12,
  parameter int CLASS_W = 3
);
  logic               pred_valid;
  logic               pred_ready;
  logic [NODE_W-1:0]  pred_node;
  logic [CLASS_W-1:0] pred_class;

  modport master (
    output pred_valid, pred_node, pred_class,
    input  pred_ready
  );

  modport slave (
    input  pred_valid, pred_node, pred_class,
    output pred_ready
  );
endinterface

// File: rtl/gat_argmax_cmp.sv
// gat_argmax_cmp: tags issued reads through RDL stages, keeps running
// signed max/index; GAT_ARGMAX_SCORE_EN adds clr, max_o, tie_cnt.
module gat_argmax_cmp #(
  parameter int W       = 32,
  parameter int RDL     = 1,
  parameter int CLASS_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_v,
  input  logic [CLASS_W-1:0] in_idx,
  input  logic [W-1:0]       dout,
`ifdef GAT_ARGMAX_SCORE_EN
  input  logic               clr,
  output logic [W-1:0]       max_o,
  output logic [15:0]        tie_cnt,
`endif
  output logic [CLASS_W-1:0] idx_o
);

  logic [RDL-1:0]     v_sr;
  logic [CLASS_W-1:0] j_sr [RDL];
  logic [W-1:0]       max_q;
  logic [CLASS_W-1:0] idx_q;
  logic               v;
  logic               first;
  logic               gt;

  assign v     = v_sr[RDL-1];
  assign first = (j_sr[RDL-1] == '0);
  assign gt    = $signed(dout) > $signed(max_q);
  assign idx_o = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr <= '0;
      for (int i = 0; i < RDL; i++) j_sr[i] <= '0;
    end else begin
      v_sr[0] <= in_v;
      j_sr[0] <= in_idx;
      for (int i = 1; i < RDL; i++) begin
        v_sr[i] <= v_sr[i-1];
        j_sr[i] <= j_sr[i-1];
      end
    end
  end

  // ties keep the earlier (lower) index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (v && (first || gt)) begin
      max_q <= dout;
      idx_q <= j_sr[RDL-1];
    end
  end

`ifdef GAT_ARGMAX_SCORE_EN
  logic [15:0] tie_q;

  assign max_o   = max_q;
  assign tie_cnt = tie_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_q <= '0;
    end else if (clr) begin
      tie_q <= '0;
    end else if (v && !first && dout == max_q
                 && tie_q != 16'hFFFF) begin
      tie_q <= tie_q + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/gat_feat_argmax.sv
// gat_feat_argmax: on gat_ready rise, reads each node's logits via BRAM port B and streams argmax.
// Ports: clk, rst_n, gat_ready, feat_bram_addrb/dout, pred stream, busy, done; GAT_ARGMAX_SCORE_EN: pred_score, tie_cnt.
module gat_feat_argmax
  import gat_argmax_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NUM_FEATURE_FINAL  = 7,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int FEAT_STRIDE        = NUM_FEATURE_FINAL,
  parameter int RD_LATENCY         = 1,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int CLASS_W            = class_w(NUM_FEATURE_FINAL),
  parameter int NODE_W             = node_w(NUM_SUBGRAPHS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  gat_feat_argmax_if.master             pred,
`ifdef GAT_ARGMAX_SCORE_EN
  output logic [NEW_FEATURE_WIDTH-1:0]  pred_score,
  output logic [15:0]                   tie_cnt,
`endif
  output logic                          busy,
  output logic                          done
);

  localparam int AW = NEW_FEATURE_ADDR_W;

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_lat
    $error("RD_LATENCY out of range 1..3");
  end

  if ((NUM_SUBGRAPHS - 1) * FEAT_STRIDE + NUM_FEATURE_FINAL
      > NEW_FEATURE_DEPTH) begin : g_bad_depth
    $error("last node read exceeds feature BRAM depth");
  end

  logic [2:0]         state_q;
  logic [NODE_W-1:0]  node_q;
  logic [AW-1:0]      base_q;
  logic [AW-1:0]      addr_q;
  logic [CLASS_W-1:0] k_q;
  logic [1:0]         dcnt_q;
  logic               gr_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               start;
  logic               issue;
  logic [CLASS_W-1:0] cls;

  assign start = (state_q == S_IDLE) && gat_ready && !gr_q;
  assign issue = (state_q == S_ISSUE);

  assign feat_bram_addrb = {addr_q, 2'b00};
  assign busy            = busy_q;
  assign done            = done_q;
  assign pred.pred_valid = valid_q;
  assign pred.pred_node  = node_q;
  assign pred.pred_class = cls;

  // addr_q is preloaded so it already holds base+k during ISSUE cycle k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      node_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      gr_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gr_q   <= gat_ready;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ISSUE;
            node_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (k_q == CLASS_W'(NUM_FEATURE_FINAL - 1)) begin
            state_q <= S_DRAIN;
            dcnt_q  <= '0;
          end else begin
            k_q    <= k_q + CLASS_W'(1);
            addr_q <= addr_q + AW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == 2'(RD_LATENCY - 1)) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 2'd1;
          end
        end
        S_OUT: begin
          if (pred.pred_ready) begin
            valid_q <= 1'b0;
            if (node_q == NODE_W'(NUM_SUBGRAPHS - 1)) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_ISSUE;
              node_q  <= node_q + NODE_W'(1);
              base_q  <= base_q + AW'(FEAT_STRIDE);
              addr_q  <= base_q + AW'(FEAT_STRIDE);
              k_q     <= '0;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  gat_argmax_cmp #(
    .W       (NEW_FEATURE_WIDTH),
    .RDL     (RD_LATENCY),
    .CLASS_W (CLASS_W)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_v    (issue),
    .in_idx  (k_q),
    .dout    (feat_bram_dout),
`ifdef GAT_ARGMAX_SCORE_EN
    .clr     (start),
    .max_o   (pred_score),
    .tie_cnt (tie_cnt),
`endif
    .idx_o   (cls)
  );

endmodule

// File: tb/tb_gat_feat_argmax.sv
// tb_gat_feat_argmax: two DUTs (RD_LATENCY 1 and 3) on a shared logit
// memory; scoreboard queues of expected records, directed pass sequence.
module tb_gat_feat_argmax;
  import gat_argmax_pkg::*;

  localparam int NS   = 3;
  localparam int NFF  = 7;
  localparam int NOUT = 16;
  localparam int W    = 32;
  localparam int AW   = $clog2(NS * NOUT);
  localparam int NW   = node_w(NS);
  localparam int CW   = class_w(NFF);

  typedef struct {
    pred_rec_t   rec;
    logic [31:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gat_ready = 1'b0;
  always #5 clk = ~clk;

  logic [AW+1:0] addr_a, addr_b;
  logic [W-1:0]  dout_a, rb1, rb2, rb3;
  logic          busy_a, done_a, busy_b, done_b;
`ifdef GAT_ARGMAX_SCORE_EN
  logic [W-1:0]  score_a, score_b;
  logic [15:0]   tie_a, tie_b;
`endif

  gat_feat_argmax_if #(.NODE_W(NW), .CLASS_W(CW)) pa ();
  gat_feat_argmax_if #(.NODE_W(NW), .CLASS_W(CW)) pb ();
  assign pb.pred_ready = 1'b1;

  logic [W-1:0] mem [64];
  always @(posedge clk) begin
    dout_a <= mem[addr_a[AW+1:2]];
    rb1    <= mem[addr_b[AW+1:2]];
    rb2    <= rb1;
    rb3    <= rb2;
  end

  gat_feat_argmax #(
    .NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NOUT),
    .NUM_FEATURE_FINAL(NFF), .NUM_SUBGRAPHS(NS),
    .RD_LATENCY(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready),
    .feat_bram_addrb(addr_a), .feat_bram_dout(dout_a),
    .pred(pa),
`ifdef GAT_ARGMAX_SCORE_EN
    .pred_score(score_a), .tie_cnt(tie_a),
`endif
    .busy(busy_a), .done(done_a)
  );

  gat_feat_argmax #(
    .NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NOUT),
    .NUM_FEATURE_FINAL(NFF), .NUM_SUBGRAPHS(NS),
    .RD_LATENCY(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready),
    .feat_bram_addrb(addr_b), .feat_bram_dout(rb3),
    .pred(pb),
`ifdef GAT_ARGMAX_SCORE_EN
    .pred_score(score_b), .tie_cnt(tie_b),
`endif
    .busy(busy_b), .done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int recs_a = 0, recs_b = 0;
  int dn_a = 0, dn_b = 0;
  int last_b = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [AW+1:0] alog[$];
  logic [AW+1:0] alast = '1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input int c, input logic [31:0] s);
    exp_t e;
    e.rec.node = 16'(n);
    e.rec.cls  = 8'(c);
    e.score    = s;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (done_a) dn_a++;
    if (done_b) dn_b++;
    if (busy_a && pa.pred_node == 2 && !pa.pred_valid
        && addr_a != alast) begin
      alog.push_back(addr_a);
      alast = addr_a;
    end
    if (pa.pred_valid && pa.pred_ready) begin
      recs_a++;
      chk("a_rec_expected", 64'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_node", 64'(pa.pred_node), 64'(ea.rec.node));
        chk("a_class", 64'(pa.pred_class), 64'(ea.rec.cls));
`ifdef GAT_ARGMAX_SCORE_EN
        chk("a_score", 64'(score_a), 64'(ea.score));
`endif
      end
    end
    if (pb.pred_valid && pb.pred_ready) begin
      recs_b++;
      chk("b_rec_expected", 64'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_node", 64'(pb.pred_node), 64'(eb.rec.node));
        chk("b_class", 64'(pb.pred_class), 64'(eb.rec.cls));
`ifdef GAT_ARGMAX_SCORE_EN
        chk("b_score", 64'(score_b), 64'(eb.score));
`endif
        if (eb.rec.node != 0)
          chk("b_node_period", 64'(cyc - last_b), 11);
      end
      last_b = cyc;
    end
  end

  initial begin
    int v[21];
    logic got;
    logic [3:0] bad;
    logic [NW-1:0] sn_node;
    logic [CW-1:0] sn_cls;
    int ta, tb;

    v = '{1, 5, -3, 5, 0, 2, 4,
          -9, -2, -7, -100, -3, -2, -50,
          32'sh80000000, 0, -1, 5, 100, 32'sh7fffffff, 32'sh80000000};
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 21; i++) mem[i] = v[i];
    pa.pred_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(pa.pred_valid), 0);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_addr", 64'(addr_a), 0);
    chk("rst_node", 64'(pa.pred_node), 0);
    chk("rst_class", 64'(pa.pred_class), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // pass 1: stall on node 1, gat_ready re-edge while busy
    dn_a = 0; dn_b = 0; recs_a = 0; recs_b = 0;
    push(0, 1, 5);
    push(1, 1, -2);
    push(2, 5, 32'h7fffffff);
    gat_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pa.pred_valid) begin got = 1; break; end
    end
    chk("wait_node0", 64'(got), 1);
    @(negedge clk);
    pa.pred_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pa.pred_valid) begin got = 1; break; end
    end
    chk("wait_node1", 64'(got), 1);
    sn_node = pa.pred_node;
    sn_cls  = pa.pred_class;
    chk("stall_addr", 64'(addr_a), 52);
    bad = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) gat_ready = 1'b0;
      if (i == 1) gat_ready = 1'b1;
      @(negedge clk);
      if (!pa.pred_valid) bad[0] = 1'b1;
      if (pa.pred_node != sn_node) bad[1] = 1'b1;
      if (pa.pred_class != sn_cls) bad[2] = 1'b1;
      if (addr_a != 8'd52) bad[3] = 1'b1;
    end
    chk("stall_hold", 64'(bad), 0);
    pa.pred_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a) begin got = 1; break; end
    end
    chk("pass1_done", 64'(got), 1);
    repeat (5) @(negedge clk);
    chk("p1_recs_a", 64'(recs_a), 3);
    chk("p1_recs_b", 64'(recs_b), 3);
    chk("p1_qa_empty", 64'(qa.size()), 0);
    chk("p1_qb_empty", 64'(qb.size()), 0);
    chk("p1_done_a", 64'(dn_a), 1);
    chk("p1_done_b", 64'(dn_b), 1);
    chk("p1_idle_a", 64'(busy_a), 0);
    chk("p1_idle_b", 64'(busy_b), 0);
    chk("addr_count", 64'(alog.size()), 7);
    for (int k = 0; k < 7; k++)
      if (k < alog.size())
        chk("addr_node2", 64'(alog[k]), 64'(56 + 4 * k));
`ifdef GAT_ARGMAX_SCORE_EN
    chk("p1_tie_a", 64'(tie_a), 2);
    chk("p1_tie_b", 64'(tie_b), 2);
`endif

    // pass 2: async reset in node 1, cycle 3
    gat_ready = 1'b0;
    @(negedge clk);
    dn_a = 0; dn_b = 0; recs_a = 0; recs_b = 0;
    push(0, 1, 5);
    gat_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pa.pred_valid) begin got = 1; break; end
    end
    chk("p2_wait_node0", 64'(got), 1);
    repeat (4) @(negedge clk);
    chk("p2_node_before", 64'(pa.pred_node), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(pa.pred_valid), 0);
    chk("abort_busy", 64'(busy_a), 0);
    chk("abort_addr", 64'(addr_a), 0);
    chk("abort_node", 64'(pa.pred_node), 0);
    chk("abort_class", 64'(pa.pred_class), 0);
    chk("abort_done", 64'(done_a), 0);
    gat_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("p2_no_done_a", 64'(dn_a), 0);
    chk("p2_no_done_b", 64'(dn_b), 0);
    chk("p2_recs_a", 64'(recs_a), 1);
    chk("p2_recs_b", 64'(recs_b), 1);
    chk("p2_qa_empty", 64'(qa.size()), 0);

    // pass 3: restart from node 0 with new data, ready tied high
    for (int i = 0; i < NFF; i++) begin
      mem[i]     = (i < 3) ? 32'd3 : ((i == 3) ? 32'd1 : 32'd0);
      mem[7 + i] = 32'(i);
    end
    rst_n = 1'b1;
    @(negedge clk);
    dn_a = 0; dn_b = 0; recs_a = 0; recs_b = 0;
    push(0, 0, 3);
    push(1, 6, 6);
    push(2, 5, 32'h7fffffff);
    gat_ready = 1'b1;
    ta = 0; tb = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done_a && ta == 0) ta = i;
      if (done_b && tb == 0) tb = i;
      if (ta != 0 && tb != 0) break;
    end
    chk("pass_time_a", 64'(ta), 28);
    chk("pass_time_b", 64'(tb), 34);
    repeat (3) @(negedge clk);
    chk("p3_recs_a", 64'(recs_a), 3);
    chk("p3_recs_b", 64'(recs_b), 3);
    chk("p3_qa_empty", 64'(qa.size()), 0);
    chk("p3_qb_empty", 64'(qb.size()), 0);
`ifdef GAT_ARGMAX_SCORE_EN
    chk("p3_tie_a", 64'(tie_a), 2);
    chk("p3_tie_b", 64'(tie_b), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
